// File: rtl/mul_partial_combiner.sv
// Folds three 16x16 partial products into the low 32 bits of a 32x32 product.
// Two-stage valid/ready pipeline; define MUL_COMB_OUT_REG_EN for a third output register stage.
module mul_partial_combiner #(
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_p1,
    input  logic [31:0]      in_p2,
    input  logic [31:0]      in_p3,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    logic             s1_valid_q, s1_valid_d;
    logic [31:0]      s1_p1_q, s1_p1_d;
    logic [15:0]      s1_cross_q, s1_cross_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    logic             s2_valid_q, s2_valid_d;
    logic [31:0]      s2_result_q, s2_result_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

    logic s1_ld, s2_ld, accept;

    // Upper halves of the cross products only affect bits above 31.
    logic unused_cross_hi;
    assign unused_cross_hi = ^{in_p2[31:16], in_p3[31:16]};

`ifdef MUL_COMB_OUT_REG_EN
    logic             s3_valid_q, s3_valid_d;
    logic [31:0]      s3_result_q, s3_result_d;
    logic [TAG_W-1:0] s3_tag_q, s3_tag_d;
    logic             s3_ld;

    assign s3_ld = !s3_valid_q || out_ready;
    assign s2_ld = !s2_valid_q || s3_ld;
`else
    assign s2_ld = !s2_valid_q || out_ready;
`endif
    assign s1_ld    = !s1_valid_q || s2_ld;
    assign in_ready = s1_ld && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_p1_d     = s1_p1_q;
        s1_cross_d  = s1_cross_q;
        s1_tag_d    = s1_tag_q;
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_tag_d    = s2_tag_q;
`ifdef MUL_COMB_OUT_REG_EN
        s3_valid_d  = s3_valid_q;
        s3_result_d = s3_result_q;
        s3_tag_d    = s3_tag_q;
`endif
        if (flush) begin
            // Kill valids only; data registers are left as they are.
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
`ifdef MUL_COMB_OUT_REG_EN
            s3_valid_d = 1'b0;
`endif
        end else begin
            if (s1_ld) begin
                s1_valid_d = accept;
                if (accept) begin
                    s1_p1_d    = in_p1;
                    s1_cross_d = in_p2[15:0] + in_p3[15:0];
                    s1_tag_d   = in_tag;
                end
            end
            if (s2_ld) begin
                s2_valid_d = s1_valid_q;
                if (s1_valid_q) begin
                    s2_result_d = s1_p1_q + {s1_cross_q, 16'h0000};
                    s2_tag_d    = s1_tag_q;
                end
            end
`ifdef MUL_COMB_OUT_REG_EN
            if (s3_ld) begin
                s3_valid_d = s2_valid_q;
                if (s2_valid_q) begin
                    s3_result_d = s2_result_q;
                    s3_tag_d    = s2_tag_q;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_p1_q     <= '0;
            s1_cross_q  <= '0;
            s1_tag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_tag_q    <= '0;
`ifdef MUL_COMB_OUT_REG_EN
            s3_valid_q  <= 1'b0;
            s3_result_q <= '0;
            s3_tag_q    <= '0;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_p1_q     <= s1_p1_d;
            s1_cross_q  <= s1_cross_d;
            s1_tag_q    <= s1_tag_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_tag_q    <= s2_tag_d;
`ifdef MUL_COMB_OUT_REG_EN
            s3_valid_q  <= s3_valid_d;
            s3_result_q <= s3_result_d;
            s3_tag_q    <= s3_tag_d;
`endif
        end
    end

`ifdef MUL_COMB_OUT_REG_EN
    assign out_valid  = s3_valid_q;
    assign out_result = s3_result_q;
    assign out_tag    = s3_tag_q;
    assign busy       = s1_valid_q || s2_valid_q || s3_valid_q;
`else
    assign out_valid  = s2_valid_q;
    assign out_result = s2_result_q;
    assign out_tag    = s2_tag_q;
    assign busy       = s1_valid_q || s2_valid_q;
`endif

endmodule

// File: tb/tb_mul_partial_combiner.sv
// Directed bench for mul_partial_combiner: vector table plus stall, flush and reset sequences.
module tb_mul_partial_combiner;

    localparam int unsigned TAG_W = 5;
`ifdef MUL_COMB_OUT_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_p1, in_p2, in_p3;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    int n_cmp = 0;
    int n_bad = 0;

    mul_partial_combiner #(.TAG_W(TAG_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_p1      (in_p1),
        .in_p2      (in_p2),
        .in_p3      (in_p3),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [31:0]      p1;
        logic [31:0]      p2;
        logic [31:0]      p3;
        logic [TAG_W-1:0] tag;
        logic [31:0]      exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One op with out_ready=1: checks acceptance, latency, result and tag.
    task automatic run_op(input vec_t v);
        int cyc;
        in_valid = 1'b1;
        in_p1 = v.p1; in_p2 = v.p2; in_p3 = v.p3; in_tag = v.tag;
        out_ready = 1'b1;
        #1;
        chk({v.name, " in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_p1 = 32'hDEAD_BEEF; in_p2 = 32'hDEAD_BEEF; in_p3 = 32'hDEAD_BEEF;
        #1;
        cyc = 1;
        while (!out_valid && cyc < 12) begin
            tick();
            #1;
            cyc++;
        end
        chk({v.name, " latency"}, 32'(cyc), 32'(LAT));
        chk({v.name, " result"}, out_result, v.exp);
        chk({v.name, " tag"}, 32'(out_tag), 32'(v.tag));
        tick();
        #1;
        chk({v.name, " drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        vec_t vecs[5];
        int   sent, got, cyc;
        logic             prev_stall;
        logic [31:0]      prev_res;
        logic [TAG_W-1:0] prev_tag;
        logic             saw_out;

        vecs[0] = '{"basic",    32'h0000_000F, 32'h0000_0000, 32'h0000_0000, 5'd3,  32'h0000_000F};
        vecs[1] = '{"full",     32'h4B4D_2080, 32'hFFFF_B020, 32'hABCD_28C0, 5'd7,  32'h242D_2080};
        vecs[2] = '{"crosswrap",32'h0000_1234, 32'h0000_8000, 32'h0000_8000, 5'd12, 32'h0000_1234};
        vecs[3] = '{"p1wrap",   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 5'd31, 32'h0000_FFFF};
        vecs[4] = '{"crossmax", 32'h0000_0000, 32'h0000_FFFF, 32'h0000_FFFF, 5'd10, 32'hFFFE_0000};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_p1 = '0; in_p2 = '0; in_p3 = '0; in_tag = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst out_result", out_result, 32'd0);
        chk("rst out_tag", 32'(out_tag), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        tick();

        for (int i = 0; i < 5; i++) run_op(vecs[i]);

        // Back-to-back with a 4-cycle stall, then drain in order.
        sent = 0; got = 0; prev_stall = 1'b0; prev_res = '0; prev_tag = '0;
        for (cyc = 0; cyc < 40 && got < 4; cyc++) begin
            out_ready = (cyc >= 4);
            in_valid  = (sent < 4);
            in_p1 = 32'(sent); in_p2 = 32'd1; in_p3 = 32'd1; in_tag = TAG_W'(sent);
            #1;
            if (cyc == 3) begin
                chk("stall in_ready", 32'(in_ready), 32'd0);
                chk("stall out_valid", 32'(out_valid), 32'd1);
                chk("stall busy", 32'(busy), 32'd1);
            end
            if (prev_stall) begin
                chk("stall result stable", out_result, prev_res);
                chk("stall tag stable", 32'(out_tag), 32'(prev_tag));
            end
            prev_stall = out_valid && !out_ready;
            prev_res = out_result;
            prev_tag = out_tag;
            if (out_valid && out_ready) begin
                chk("b2b result", out_result, 32'h0002_0000 + 32'(got));
                chk("b2b tag", 32'(out_tag), 32'(got));
                got++;
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        in_valid = 1'b0;
        chk("b2b count", 32'(got), 32'd4);
        tick();
        #1;
        chk("b2b no dup", 32'(out_valid), 32'd0);
        chk("b2b idle", 32'(busy), 32'd0);

        // Flush with two ops in flight and a third presented alongside flush.
        saw_out = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_p1 = 32'h100 + 32'(k); in_p2 = '0; in_p3 = '0; in_tag = TAG_W'(20 + k);
            flush = (k == 2);
            #1;
            if (k == 2) chk("flush in_ready", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) saw_out = 1'b1;
            tick();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("flush busy", 32'(busy), 32'd0);
        for (int k = 0; k < 5; k++) begin
            if (out_valid) saw_out = 1'b1;
            tick();
        end
        chk("flush no output", 32'(saw_out), 32'd0);
        run_op(vecs[1]);

        // Reset in the middle of an op.
        in_valid = 1'b1;
        in_p1 = 32'h5555_0000; in_p2 = 32'h1; in_p3 = 32'h1; in_tag = 5'd9;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst out_result", out_result, 32'd0);
        saw_out = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (out_valid) saw_out = 1'b1;
            tick();
        end
        chk("midrst no output", 32'(saw_out), 32'd0);
        run_op(vecs[4]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
